seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Parametrised, iterative unsigned divider. It is the sequential successor to the fixed 16-bit combinational divide-by-3 block.
- Divisor is a run-time operand instead of a fixed constant. Produces both quotient and remainder.
- Restoring algorithm, one quotient bit per clock, with a start/busy/done handshake.
- Sits in the FPGA datapath wherever a division is too wide or too infrequent to justify a combinational array.

Parameters:
- WIDTH, 16, bit width of dividend, divisor, quotient and remainder (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only while busy=0.
- dividend  input  WIDTH  unsigned dividend; captured on an accepted start.
- divisor  input  WIDTH  unsigned divisor; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; results valid from this cycle onward.
- quotient  output  WIDTH  unsigned quotient; held until the next accepted start.
- remainder  output  WIDTH  unsigned remainder; held until the next accepted start.
- div_by_zero  output  1  high with done when the captured divisor was 0; held with the results.

Behaviour:
- Reset (clk edge with rst=1):
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and working registers are cleared.
  - rst has priority over everything, including a mid-operation RUN; the aborted result is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with divisor!=0: capture operands, set partial remainder=0, counter=WIDTH, go to RUN.
  - start=1 with divisor=0: go directly to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
- RUN, one iteration per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract divisor from the partial remainder, using a (WIDTH+1)-bit difference so no overflow is lost.
  - Difference non-negative: keep it and shift in quotient bit 1. Otherwise restore and shift in 0.
  - Decrement counter. After the WIDTH-th iteration go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, results registered.
  - Then goes to IDLE, unless start=1 in this cycle, which is accepted exactly as in IDLE (back-to-back operation).
- busy:
  - busy=1 exactly while in RUN.
  - start while busy=1 is ignored; operands are not re-captured.
- Latency, with start high in cycle 0:
  - busy is high in cycles 1..WIDTH.
  - done is high in cycle WIDTH+1.
  - Divide-by-zero: done in cycle 1, and busy never rises.
- Results:
  - Satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.
  - quotient/remainder/div_by_zero update only in the cycle done rises; they are stable at all other times.
- dividend and divisor may change freely after capture without affecting the operation in flight.

Test Plan:
- WIDTH=16; start with 21/3 -> busy in cycles 1..16, done in cycle 17, quotient=7, remainder=0, div_by_zero=0.
- Sweep 3/3, 8/3, 0/3, 1/3, 2/3 -> (1,0), (2,2), (0,0), (0,1), (0,2), matching the previous divide-by-3 results. Then 65535/1 -> (65535,0) and 1000/65535 -> (0,1000).
- 1234/0 -> done in cycle 1, quotient=16'hFFFF, remainder=1234, div_by_zero=1; busy stays 0.
- Start 100/7, then pulse start with 50/5 in cycle 5 and change operands -> second request ignored; result (14,2) in cycle 17.
- Start 21/3 and assert rst in cycle 8 -> next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse follows. Then start 9/4 -> (2,1).
- Back-to-back: assert start with 45/6 in the done cycle of a 21/3 operation -> done for 21/3, then busy immediately, done 17 cycles later with (7,3).
- Randomised run of 1000 operand pairs at WIDTH=8 and WIDTH=32 -> every result matches the reference model's / and %.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock; done arrives WIDTH+1 cycles after start (cycle 1 on divide-by-zero).
// Backpressure: start is honoured only while busy=0 (IDLE or the DONE cycle); requests during RUN are dropped.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             fits;
  logic             last_iter;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (divisor == '0) ? DONE : RUN;
        else       state_d = IDLE;
      end
      RUN:     if (last_iter) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign accept    = start && (state_q != RUN);
  assign last_iter = (cnt_q == CW'(1));

  // Partial remainder is always < divisor, so in the (WIDTH+1)-bit difference
  // the top bit is set exactly when the trial subtraction went negative.
  assign shifted = {prem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = ~diff[WIDTH];

  always_comb begin
    cnt_d  = cnt_q;
    prem_d = prem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (accept) begin
      if (divisor == '0) begin
        quot_d = '1;
        rem_d  = dividend;
        dbz_d  = 1'b1;
      end else begin
        dvd_d  = dividend;
        dvs_d  = divisor;
        prem_d = '0;
        cnt_d  = CW'(WIDTH);
      end
    end else if (state_q == RUN) begin
      prem_d = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      dvd_d  = {dvd_q[WIDTH-2:0], fits};
      cnt_d  = cnt_q - CW'(1);
      if (last_iter) begin
        quot_d = {dvd_q[WIDTH-2:0], fits};
        rem_d  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dbz_d  = 1'b0;
      end
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: cycle-level reference model on a 16-bit instance, directed cases, and random sweeps at 8 and 32 bits.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // 16-bit instance
  logic        rst16 = 1'b1, start16 = 1'b0;
  logic [15:0] dvd16 = '0, dvs16 = '0;
  logic        busy16, done16, z16;
  logic [15:0] q16, r16;

  seq_divider #(.WIDTH(16)) u_div16 (
    .clk(clk), .rst(rst16), .start(start16), .dividend(dvd16), .divisor(dvs16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(z16)
  );

  // 8-bit instance
  logic        rst8 = 1'b1, start8 = 1'b0;
  logic [7:0]  dvd8 = '0, dvs8 = '0;
  logic        busy8, done8, z8;
  logic [7:0]  q8, r8;

  seq_divider #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst8), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
  );

  // 32-bit instance
  logic        rst32 = 1'b1, start32 = 1'b0;
  logic [31:0] dvd32 = '0, dvs32 = '0;
  logic        busy32, done32, z32;
  logic [31:0] q32, r32;

  seq_divider #(.WIDTH(32)) u_div32 (
    .clk(clk), .rst(rst32), .start(start32), .dividend(dvd32), .divisor(dvs32),
    .busy(busy32), .done(done32), .quotient(q32), .remainder(r32), .div_by_zero(z32)
  );

  // Reference model for the 16-bit instance: an accepted start schedules the
  // answer (a/b, a%b) to appear 16 cycles later; busy covers the wait.
  logic        m_busy = 1'b0, m_done = 1'b0, m_z = 1'b0;
  logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst16) begin
      m_busy = 1'b0; m_done = 1'b0; m_q = '0; m_r = '0; m_z = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_q = p_q; m_r = p_r; m_z = 1'b0;
        end
      end else if (start16) begin
        if (dvs16 == 16'd0) begin
          m_done = 1'b1; m_q = 16'hFFFF; m_r = dvd16; m_z = 1'b1;
        end else begin
          m_left = 16; p_q = dvd16 / dvs16; p_r = dvd16 % dvs16;
        end
      end
      m_busy = (m_left > 0);
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc busy", busy16, m_busy);
      check("cyc done", done16, m_done);
      check("cyc quotient", q16, m_q);
      check("cyc remainder", r16, m_r);
      check("cyc div_by_zero", z16, m_z);
    end
  end

  task automatic launch16(input logic [15:0] a, input logic [15:0] b);
    start16 = 1'b1; dvd16 = a; dvs16 = b;
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic wait_done16(input int from, output int at);
    at = from;
    while (!done16 && at < from + 60) begin
      @(negedge clk);
      at++;
    end
  endtask

  task automatic op16(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eq, input logic [15:0] er);
    int at;
    launch16(a, b);
    wait_done16(1, at);
    check({name, " done cycle"}, at, 17);
    check({name, " quotient"}, q16, eq);
    check({name, " remainder"}, r16, er);
    check({name, " div_by_zero"}, z16, 1'b0);
  endtask

  initial begin
    int at;
    int pulses;
    logic [15:0] sw_a [7] = '{16'd3, 16'd8, 16'd0, 16'd1, 16'd2, 16'd65535, 16'd1000};
    logic [15:0] sw_b [7] = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd1, 16'd65535};
    logic [15:0] sw_q [7] = '{16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd65535, 16'd0};
    logic [15:0] sw_r [7] = '{16'd0, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0, 16'd1000};

    repeat (2) @(negedge clk);
    check("reset busy", busy16, 1'b0);
    check("reset done", done16, 1'b0);
    check("reset quotient", q16, 16'd0);
    check("reset remainder", r16, 16'd0);
    check("reset div_by_zero", z16, 1'b0);
    rst16 = 1'b0; rst8 = 1'b0; rst32 = 1'b0;
    chk_en = 1'b1;

    launch16(16'd21, 16'd3);
    check("21/3 busy cycle1", busy16, 1'b1);
    wait_done16(1, at);
    check("21/3 done cycle", at, 17);
    check("21/3 busy in done cycle", busy16, 1'b0);
    check("21/3 quotient", q16, 16'd7);
    check("21/3 remainder", r16, 16'd0);
    check("21/3 div_by_zero", z16, 1'b0);

    for (int i = 0; i < 7; i++) op16($sformatf("sweep%0d", i), sw_a[i], sw_b[i], sw_q[i], sw_r[i]);

    launch16(16'd1234, 16'd0);
    check("div0 done cycle1", done16, 1'b1);
    check("div0 busy", busy16, 1'b0);
    check("div0 quotient", q16, 16'hFFFF);
    check("div0 remainder", r16, 16'd1234);
    check("div0 flag", z16, 1'b1);

    // start during RUN must be dropped, and operand changes must not leak in
    @(negedge clk);
    launch16(16'd100, 16'd7);
    repeat (4) @(negedge clk);
    start16 = 1'b1; dvd16 = 16'd50; dvs16 = 16'd5;
    @(negedge clk);
    start16 = 1'b0; dvd16 = 16'd999; dvs16 = 16'd1;
    wait_done16(6, at);
    check("ignored-start done cycle", at, 17);
    check("ignored-start quotient", q16, 16'd14);
    check("ignored-start remainder", r16, 16'd2);

    @(negedge clk);
    launch16(16'd21, 16'd3);
    repeat (7) @(negedge clk);
    rst16 = 1'b1;
    @(negedge clk);
    rst16 = 1'b0;
    check("abort busy", busy16, 1'b0);
    check("abort done", done16, 1'b0);
    check("abort quotient", q16, 16'd0);
    check("abort remainder", r16, 16'd0);
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done16) pulses++;
    end
    check("abort no done pulse", pulses, 0);
    op16("9/4 after abort", 16'd9, 16'd4, 16'd2, 16'd1);

    @(negedge clk);
    launch16(16'd21, 16'd3);
    wait_done16(1, at);
    check("b2b first done cycle", at, 17);
    check("b2b first quotient", q16, 16'd7);
    start16 = 1'b1; dvd16 = 16'd45; dvs16 = 16'd6;
    @(negedge clk);
    start16 = 1'b0;
    check("b2b busy immediately", busy16, 1'b1);
    check("b2b result held", q16, 16'd7);
    wait_done16(18, at);
    check("b2b second done cycle", at, 34);
    check("b2b second quotient", q16, 16'd7);
    check("b2b second remainder", r16, 16'd3);
    @(negedge clk);
    chk_en = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      int n;
      a = 8'($urandom);
      b = (i % 50 == 0) ? 8'd0 : 8'($urandom);
      start8 = 1'b1; dvd8 = a; dvs8 = b;
      @(negedge clk);
      start8 = 1'b0; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
      n = 1;
      while (!done8 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("w8 done cycle", n, (b == 8'd0) ? 1 : 9);
      check("w8 quotient", q8, (b == 8'd0) ? 8'hFF : a / b);
      check("w8 remainder", r8, (b == 8'd0) ? a : a % b);
      check("w8 div_by_zero", z8, b == 8'd0);
    end

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      int n;
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 1000));
        2:       b = 32'($urandom_range(1, 65535));
        default: b = (i % 100 == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      endcase
      start32 = 1'b1; dvd32 = a; dvs32 = b;
      @(negedge clk);
      start32 = 1'b0; dvd32 = $urandom; dvs32 = $urandom;
      n = 1;
      while (!done32 && n < 45) begin
        @(negedge clk);
        n++;
      end
      check("w32 done cycle", n, (b == 32'd0) ? 1 : 33);
      check("w32 quotient", q32, (b == 32'd0) ? 32'hFFFF_FFFF : a / b);
      check("w32 remainder", r32, (b == 32'd0) ? a : a % b);
      check("w32 div_by_zero", z32, b == 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
